matrix_multiply_core3x3_sequencer: RTL and testbench
====================================================

MATRIX_MULTIPLY_CORE3X3_SEQUENCER -- requirements
Module: matrix_multiply_core3x3_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, element width of coefficients, vector elements and results.
REQ-002 SHALL have parameter CORE_LAT, default 3, range 1..15, fixed latency in cycles of the 3x3 multiply core from core_start to valid core_res.
REQ-003 SHALL have ports:
  system1000       in   1          clock, rising edge
  system1000_rstn  in   1          reset, asynchronous, active-low
  cfg_we           in   1          coefficient write strobe
  cfg_addr         in   4          coefficient index 0..8, row-major
  cfg_wdata        in   DATA_W     coefficient value
  cfg_commit       in   1          pulse: shadow bank becomes active
  in_valid         in   1          input vector valid
  in_ready         out  1          sequencer accepts input vector
  in_data          in   3*DATA_W   vector, element 0 at LSBs
  core_start       out  1          one-cycle launch pulse to core
  core_coef        out  9*DATA_W   active coefficients, index 0 at LSBs
  core_vec         out  3*DATA_W   latched vector to core
  core_res         in   3*DATA_W   core result
  out_valid        out  1          result valid
  out_ready        in   1          downstream accepts result
  out_data         out  3*DATA_W   latched result
  busy             out  1          FSM not in IDLE
  err_addr         out  1          sticky: write with cfg_addr > 8 seen

Function
REQ-004 SHALL implement FSM states IDLE, LAUNCH, WAIT, HOLD.
REQ-005 IDLE: in_ready=1 only when no commit is pending; in_valid&in_ready latches in_data into core_vec and moves to LAUNCH.
REQ-006 LAUNCH: core_start=1 for exactly this one cycle; load wait counter with CORE_LAT-1; go to WAIT.
REQ-007 WAIT: decrement counter each cycle; at count 0, capture core_res into out_data and go to HOLD; core_res is sampled in the cycle exactly CORE_LAT cycles after the core_start cycle.
REQ-008 HOLD: out_valid=1 and out_data held stable until out_valid&out_ready; then go to IDLE; out_ready in other states is ignored.
REQ-009 Latency: acceptance edge T -> core_start during cycle T+1 -> out_valid first high in cycle T+2+CORE_LAT; no overlap of vectors; throughput one vector per CORE_LAT+3 cycles minimum.
REQ-010 cfg_we with cfg_addr 0..8 SHALL write the shadow bank in any FSM state; cfg_addr 9..15 SHALL be discarded and set err_addr.
REQ-011 cfg_commit in IDLE SHALL copy shadow to active on the next edge, with in_ready=0 in the commit cycle; cfg_commit outside IDLE SHALL set a pending flag and be applied in the first IDLE cycle, before any new acceptance.
REQ-012 Simultaneous cfg_we and cfg_commit SHALL commit the shadow contents as they were before the write; the write lands in shadow only.
REQ-013 core_coef SHALL change only on commit and never between acceptance and the following out_valid&out_ready handshake.
REQ-014 busy=1 in LAUNCH, WAIT and HOLD.

Reset
REQ-015 Reset SHALL force IDLE, in_ready=1, core_start=0, out_valid=0, busy=0, err_addr=0, pending commit=0, core_vec=0, out_data=0, and both coefficient banks=0.
REQ-016 Reset asserted mid-operation SHALL abort immediately; the in-flight vector is lost and no out_valid is produced for it.

Configuration
REQ-017 With MMC3X3_SEQ_SHADOW_EN defined, coefficients SHALL be double-buffered as in REQ-010..013.
REQ-018 Without MMC3X3_SEQ_SHADOW_EN, cfg_we SHALL write the active bank directly and SHALL be accepted only in IDLE; writes outside IDLE are dropped and set err_addr; cfg_commit is ignored; in_ready depends only on state.

Structure
REQ-019 Package matrix_multiply_core3x3_pkg SHALL hold DATA_W default, COEF_N=9, VEC_N=3, the FSM state typedef and the coefficient index width.
REQ-020 Sub-module matrix_multiply_core3x3_coef_bank SHALL contain the shadow/active banks, address check and commit logic.

Verification
REQ-021 Reset, then load coefficients 1..9, commit, send vector {1,2,3} -> core_start exactly 1 cycle after acceptance; out_valid in cycle T+5 (CORE_LAT=3); out_data equals core_res {14,32,50}.
REQ-022 out_ready held low 10 cycles in HOLD -> out_data stable, in_ready=0 throughout; release -> IDLE next cycle.
REQ-023 cfg_commit pulsed during WAIT with new shadow values -> core_coef unchanged until handshake; new values active in the first IDLE cycle; in_ready=0 in that cycle.
REQ-024 cfg_we with cfg_addr=12 -> no bank change; err_addr=1 until reset.
REQ-025 Reset asserted during WAIT -> all outputs at reset values on the same edge; no out_valid produced after reset release.
REQ-026 Build without MMC3X3_SEQ_SHADOW_EN: write index 4 = 7 in IDLE -> core_coef element 4 = 7 next cycle; same write during WAIT -> dropped and err_addr=1.

Source files
------------

// File: rtl/matrix_multiply_core3x3_pkg.sv
// Shared constants, FSM state type and helpers for the 3x3 matrix-multiply sequencer.
// The MMC3X3_SEQ_SHADOW_EN build macro selects double-buffered coefficients.
package matrix_multiply_core3x3_pkg;

    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned COEF_N         = 9;
    localparam int unsigned VEC_N          = 3;
    localparam int unsigned COEF_IDX_W     = 4;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StHold
    } seq_state_e;

    function automatic logic coef_addr_ok(input logic [COEF_IDX_W-1:0] addr);
        return addr <= COEF_IDX_W'(COEF_N - 1);
    endfunction

endpackage

// File: rtl/matrix_multiply_core3x3_coef_bank.sv
// Coefficient storage with address check and commit logic.
// MMC3X3_SEQ_SHADOW_EN: shadow/active double buffering; otherwise direct writes in IDLE only.
module matrix_multiply_core3x3_coef_bank
    import matrix_multiply_core3x3_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       we_i,
    input  logic [COEF_IDX_W-1:0]      addr_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic                       commit_i,
    input  logic                       idle_i,
    output logic [COEF_N*DATA_W-1:0]   coef_o,
    output logic                       commit_hold_o,
    output logic                       err_addr_o
);

    logic [DATA_W-1:0] active_q [COEF_N];
    logic [DATA_W-1:0] active_d [COEF_N];
    logic              err_q, err_d;
    logic              addr_ok;

    assign addr_ok = coef_addr_ok(addr_i);

`ifdef MMC3X3_SEQ_SHADOW_EN
    logic [DATA_W-1:0] shadow_q [COEF_N];
    logic [DATA_W-1:0] shadow_d [COEF_N];
    logic              pending_q, pending_d;
    logic              apply;

    // A commit seen outside IDLE waits in pending_q until the FSM returns to IDLE.
    assign apply         = idle_i & (commit_i | pending_q);
    assign commit_hold_o = commit_i | pending_q;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        err_d     = err_q;
        if (we_i) begin
            if (addr_ok) begin
                for (int unsigned i = 0; i < COEF_N; i++) begin
                    if (addr_i == COEF_IDX_W'(i)) begin
                        shadow_d[i] = wdata_i;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
        // Copy uses shadow_q, so a same-cycle write lands in shadow only.
        if (apply) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end else if (commit_i) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow_q  <= '{default: '0};
            active_q  <= '{default: '0};
            pending_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            err_q     <= err_d;
        end
    end
`else
    logic unused_commit;

    assign unused_commit = commit_i;
    assign commit_hold_o = 1'b0;

    always_comb begin
        active_d = active_q;
        err_d    = err_q;
        if (we_i) begin
            if (addr_ok && idle_i) begin
                for (int unsigned i = 0; i < COEF_N; i++) begin
                    if (addr_i == COEF_IDX_W'(i)) begin
                        active_d[i] = wdata_i;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= '{default: '0};
            err_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            err_q    <= err_d;
        end
    end
`endif

    always_comb begin
        coef_o = '0;
        for (int unsigned i = 0; i < COEF_N; i++) begin
            coef_o[i*DATA_W +: DATA_W] = active_q[i];
        end
    end

    assign err_addr_o = err_q;

endmodule

// File: rtl/matrix_multiply_core3x3_sequencer.sv
// Sequencer feeding one vector at a time to a fixed-latency 3x3 multiply core.
// Build macro MMC3X3_SEQ_SHADOW_EN enables double-buffered coefficients in the coef bank.
module matrix_multiply_core3x3_sequencer
    import matrix_multiply_core3x3_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEFAULT,
    parameter int unsigned CORE_LAT = 3
) (
    input  logic                       system1000,
    input  logic                       system1000_rstn,
    input  logic                       cfg_we,
    input  logic [COEF_IDX_W-1:0]      cfg_addr,
    input  logic [DATA_W-1:0]          cfg_wdata,
    input  logic                       cfg_commit,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [VEC_N*DATA_W-1:0]    in_data,
    output logic                       core_start,
    output logic [COEF_N*DATA_W-1:0]   core_coef,
    output logic [VEC_N*DATA_W-1:0]    core_vec,
    input  logic [VEC_N*DATA_W-1:0]    core_res,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [VEC_N*DATA_W-1:0]    out_data,
    output logic                       busy,
    output logic                       err_addr
);

    seq_state_e                state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [VEC_N*DATA_W-1:0]   vec_q, vec_d;
    logic [VEC_N*DATA_W-1:0]   res_q, res_d;
    logic                      commit_hold;
    logic                      idle;

    assign idle = (state_q == StIdle);

    matrix_multiply_core3x3_coef_bank #(
        .DATA_W (DATA_W)
    ) u_coef_bank (
        .clk_i         (system1000),
        .rst_ni        (system1000_rstn),
        .we_i          (cfg_we),
        .addr_i        (cfg_addr),
        .wdata_i       (cfg_wdata),
        .commit_i      (cfg_commit),
        .idle_i        (idle),
        .coef_o        (core_coef),
        .commit_hold_o (commit_hold),
        .err_addr_o    (err_addr)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        vec_d      = vec_q;
        res_d      = res_q;
        in_ready   = 1'b0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        case (state_q)
            StIdle: begin
                // A commit due this cycle takes priority over accepting a vector.
                in_ready = ~commit_hold;
                if (in_valid && !commit_hold) begin
                    vec_d   = in_data;
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                core_start = 1'b1;
                cnt_d      = CNT_W'(CORE_LAT - 1);
                state_d    = StWait;
            end
            StWait: begin
                if (cnt_q == '0) begin
                    res_d   = core_res;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StHold: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            vec_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            res_q   <= res_d;
        end
    end

    assign core_vec = vec_q;
    assign out_data = res_q;
    assign busy     = ~idle;

endmodule

// File: tb/tb_matrix_multiply_core3x3_sequencer.sv
// Scoreboard bench: a behavioural core and coefficient model predict every result.
// Honours MMC3X3_SEQ_SHADOW_EN to pick the expected coefficient behaviour.
module tb_matrix_multiply_core3x3_sequencer;

    localparam int DW  = 32;
    localparam int LAT = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic            cfg_we;
    logic [3:0]      cfg_addr;
    logic [DW-1:0]   cfg_wdata;
    logic            cfg_commit;
    logic            in_valid;
    logic            in_ready;
    logic [3*DW-1:0] in_data;
    logic            core_start;
    logic [9*DW-1:0] core_coef;
    logic [3*DW-1:0] core_vec;
    logic [3*DW-1:0] core_res;
    logic            out_valid;
    logic            out_ready;
    logic [3*DW-1:0] out_data;
    logic            busy;
    logic            err_addr;

    matrix_multiply_core3x3_sequencer #(
        .DATA_W   (DW),
        .CORE_LAT (LAT)
    ) dut (
        .system1000      (clk),
        .system1000_rstn (rstn),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .cfg_commit      (cfg_commit),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .core_start      (core_start),
        .core_coef       (core_coef),
        .core_vec        (core_vec),
        .core_res        (core_res),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_data        (out_data),
        .busy            (busy),
        .err_addr        (err_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3*DW-1:0] data;
        int              start_cyc;
        int              valid_cyc;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] shadow_m [9];
    logic [DW-1:0] active_m [9];
    logic          err_m;
    int            rdy_mode;

    task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout or unexpected event (cycle %0d)", name, cyc);
    endtask

    function automatic logic [3*DW-1:0] mat_vec(input logic [DW-1:0] m [9],
                                                 input logic [3*DW-1:0] v);
        logic [3*DW-1:0] r;
        logic [DW-1:0]   acc;
        r = '0;
        for (int row = 0; row < 3; row++) begin
            acc = '0;
            for (int j = 0; j < 3; j++) acc += m[3*row+j] * v[j*DW +: DW];
            r[row*DW +: DW] = acc;
        end
        return r;
    endfunction

    function automatic logic [9*DW-1:0] pack(input logic [DW-1:0] m [9]);
        logic [9*DW-1:0] p;
        for (int i = 0; i < 9; i++) p[i*DW +: DW] = m[i];
        return p;
    endfunction

    // Behavioural core: result visible exactly LAT cycles after the start cycle, noise otherwise.
    int              core_k = -1;
    logic [3*DW-1:0] core_val;
    logic [3*DW-1:0] garbage;
    logic [DW-1:0]   core_m [9];

    always @(negedge clk) begin
        garbage = {$urandom, $urandom, $urandom};
        if (!rstn) begin
            core_k = -1;
        end else if (core_start) begin
            core_k = 0;
            for (int i = 0; i < 9; i++) core_m[i] = core_coef[i*DW +: DW];
            core_val = mat_vec(core_m, core_vec);
        end else if (core_k >= 0 && core_k < LAT) begin
            core_k++;
        end else begin
            core_k = -1;
        end
    end
    assign core_res = (core_k == LAT) ? core_val : garbage;

    logic            prev_valid = 1'b0;
    logic [3*DW-1:0] prev_data;

    always @(negedge clk) begin
        if (!rstn) begin
            prev_valid = 1'b0;
        end else begin
            if (core_start) begin
                if (sb.size() == 0) fail("unexpected_core_start");
                else chk("core_start_cycle", cyc, sb[0].start_cyc);
            end
            if (out_valid) begin
                chk("in_ready_in_hold", in_ready, 1'b0);
                if (!prev_valid) begin
                    if (sb.size() == 0) fail("unexpected_out_valid");
                    else chk("out_valid_cycle", cyc, sb[0].valid_cyc);
                end else begin
                    chk("hold_stable", out_data, prev_data);
                end
                if (out_ready && sb.size() != 0) begin
                    chk("out_data", out_data, sb[0].data);
                    void'(sb.pop_front());
                end
            end
            prev_valid = out_valid;
            prev_data  = out_data;
        end
    end

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic cfg_write(input logic [3:0] a, input logic [DW-1:0] d, input logic with_commit);
        @(posedge clk);
        #1;
        cfg_we     = 1'b1;
        cfg_addr   = a;
        cfg_wdata  = d;
        cfg_commit = with_commit;
`ifdef MMC3X3_SEQ_SHADOW_EN
        if (with_commit && sb.size() == 0) active_m = shadow_m;
        if (a < 9) shadow_m[a] = d;
        else err_m = 1'b1;
`else
        if (a < 9 && sb.size() == 0) active_m[a] = d;
        else err_m = 1'b1;
`endif
        @(posedge clk);
        #1;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    // Only called while idle; the commit is visible when the task returns.
    task automatic do_commit();
        @(posedge clk);
        #1;
        cfg_commit = 1'b1;
`ifdef MMC3X3_SEQ_SHADOW_EN
        active_m = shadow_m;
`endif
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
    endtask

    task automatic send_vec(input logic [3*DW-1:0] v);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data      = mat_vec(active_m, v);
                e.start_cyc = cyc + 1;
                e.valid_cyc = cyc + 2 + LAT;
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_data  = {$urandom, $urandom, $urandom};
                return;
            end
        end
        fail("accept_timeout");
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0) return;
        end
        fail("idle_timeout");
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        fail("valid_timeout");
    endtask

    task automatic wait_handshake();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) return;
        end
        fail("handshake_timeout");
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_core_start"}, core_start, 1'b0);
        chk({tag, "_out_valid"}, out_valid, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_err_addr"}, err_addr, 1'b0);
        chk({tag, "_core_vec"}, core_vec, '0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_core_coef"}, core_coef, '0);
    endtask

    logic [9*DW-1:0] old_coef;

    initial begin
        rstn = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_commit = 1'b0;
        in_valid = 1'b0; in_data = '0; rdy_mode = 0; err_m = 1'b0;
        for (int i = 0; i < 9; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
        #12;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;

        for (int i = 0; i < 9; i++) cfg_write(4'(i), DW'(i + 1), 1'b0);
        do_commit();
        chk("coef_load", core_coef, pack(active_m));

        rdy_mode = 0;
        send_vec({32'd3, 32'd2, 32'd1});
        wait_valid();
        chk("basic_result", out_data, {32'd50, 32'd32, 32'd14});
        repeat (10) @(negedge clk);
        chk("hold_still_valid", out_valid, 1'b1);
        rdy_mode = 1;
        wait_handshake();
        @(negedge clk);
        chk("idle_after_handshake", busy, 1'b0);
        chk("ready_after_handshake", in_ready, 1'b1);

`ifdef MMC3X3_SEQ_SHADOW_EN
        cfg_write(4'd1, 32'd200, 1'b0);
        cfg_write(4'd0, 32'd100, 1'b1);
        chk("commit_with_write", core_coef, pack(active_m));
        do_commit();
        chk("commit_after_write", core_coef, pack(active_m));

        for (int i = 0; i < 9; i++) cfg_write(4'(i), $urandom, 1'b0);
        chk("shadow_only_write", core_coef, pack(active_m));
        old_coef = pack(active_m);
        rdy_mode = 0;
        send_vec({$urandom, $urandom, $urandom});
        @(posedge clk);
        #1;
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
        wait_valid();
        chk("coef_frozen_hold", core_coef, old_coef);
        repeat (3) @(negedge clk);
        chk("coef_frozen_stall", core_coef, old_coef);
        rdy_mode = 1;
        wait_handshake();
        @(negedge clk);
        chk("pending_commit_ready", in_ready, 1'b0);
        chk("pending_commit_idle", busy, 1'b0);
        @(negedge clk);
        active_m = shadow_m;
        chk("pending_commit_applied", core_coef, pack(active_m));
        chk("ready_after_pending", in_ready, 1'b1);
`else
        cfg_write(4'd4, 32'd7, 1'b0);
        chk("direct_write_elem4", core_coef[4*DW +: DW], 32'd7);
        chk("direct_write_no_err", err_addr, 1'b0);
        rdy_mode = 0;
        send_vec({$urandom, $urandom, $urandom});
        cfg_write(4'd4, 32'd99, 1'b0);
        chk("busy_write_dropped", core_coef[4*DW +: DW], 32'd7);
        chk("busy_write_err", err_addr, 1'b1);
        rdy_mode = 1;
        wait_handshake();
`endif
        rdy_mode = 2;

        wait_idle();
        cfg_write(4'd12, $urandom, 1'b0);
        chk("bad_addr_no_change", core_coef, pack(active_m));
        chk("bad_addr_err", err_addr, err_m);
        do_commit();
        chk("bad_addr_commit", core_coef, pack(active_m));

        for (int it = 0; it < 15; it++) begin
            logic early;
            int   n;
            early = 1'($urandom_range(0, 1));
            n     = $urandom_range(0, 4);
            for (int k = 0; k < 2; k++) send_vec({$urandom, $urandom, $urandom});
            if (early) for (int k = 0; k < n; k++) cfg_write(4'($urandom_range(0, 15)), $urandom, 1'b0);
            wait_idle();
            if (!early) for (int k = 0; k < n; k++) cfg_write(4'($urandom_range(0, 15)), $urandom, 1'b0);
            do_commit();
            chk("rand_coef", core_coef, pack(active_m));
            chk("rand_err", err_addr, err_m);
        end

        wait_idle();
        rdy_mode = 0;
        send_vec({$urandom, $urandom, $urandom});
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        sb.delete();
        for (int i = 0; i < 9; i++) begin
            shadow_m[i] = '0;
            active_m[i] = '0;
        end
        err_m = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (15) @(negedge clk);
        chk("no_valid_after_reset", out_valid, 1'b0);
        chk("idle_after_reset", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, want $finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
